// File: rtl/instr_loader.sv
// Streams a length-prefixed, checksummed program into instruction memory while
// holding the processor in reset until a clean load has completed.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_wordsLeft;
  logic [7:0]        r_csum;
  logic [1:0]        r_byteCnt;
  logic [23:0]       r_shift;
  logic [ADDR_W-1:0] r_wordIdx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic w_ready;
  logic w_xfer;
  logic w_start;
  logic w_lenTooBig;
  logic w_lastByte;
  logic w_lastWord;

  assign w_ready     = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  assign w_xfer      = w_ready && byte_valid_i;
  assign w_start     = start_i && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_lenTooBig = 32'(byte_i) > 32'(MAX_WORDS);
  assign w_lastByte  = (r_byteCnt == 2'd3);
  assign w_lastWord  = (r_wordsLeft == 8'd1);

  always_ff @(posedge clk_i) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start_i) w_next = LEN;
      LEN: begin
        if (w_xfer) begin
          if (byte_i == 8'd0)   w_next = CSUM;
          else if (w_lenTooBig) w_next = ERR;
          else                  w_next = DATA;
        end
      end
      DATA: if (w_xfer && w_lastByte && w_lastWord) w_next = CSUM;
      CSUM: if (w_xfer) w_next = (byte_i == r_csum) ? DONE : ERR;
      default: w_next = IDLE;
    endcase
  end

  // Word assembly, checksum and the one-cycle write strobe; the memory
  // address/data registers hold their last values between writes.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_wordsLeft <= 8'd0;
      r_csum      <= 8'd0;
      r_byteCnt   <= 2'd0;
      r_shift     <= 24'd0;
      r_wordIdx   <= '0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_we        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_wordsLeft <= 8'd0;
        r_csum      <= 8'd0;
        r_byteCnt   <= 2'd0;
        r_shift     <= 24'd0;
        r_wordIdx   <= '0;
      end else if (w_xfer) begin
        case (r_state)
          LEN: r_wordsLeft <= byte_i;
          DATA: begin
            r_csum    <= r_csum ^ byte_i;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (w_lastByte) begin
              r_we        <= 1'b1;
              r_wdata     <= {r_shift, byte_i};
              r_addr      <= r_wordIdx;
              r_wordIdx   <= r_wordIdx + ADDR_W'(1);
              r_wordsLeft <= r_wordsLeft - 8'd1;
            end else begin
              r_shift <= {r_shift[15:0], byte_i};
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    cpu_reset_o = 1'b1;
    case (r_state)
      LEN, DATA, CSUM: busy_o = 1'b1;
      DONE: begin
        done_o      = 1'b1;
        cpu_reset_o = 1'b0;
      end
      ERR: err_o = 1'b1;
      default: ;
    endcase
  end

  assign byte_ready_o = w_ready;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected memory writes go into a scoreboard
// queue as stimulus is driven and are popped when the DUT strobes a write.
module tb_instr_loader;

  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              startIn;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWdata;
  logic              cpuReset;
  logic              busy;
  logic              done;
  logic              err;

  wr_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4)) dut (
    .clk_i(clock),
    .reset(reset),
    .start_i(startIn),
    .byte_i(byteIn),
    .byte_valid_i(byteValid),
    .byte_ready_o(byteReady),
    .imem_we_o(imemWe),
    .imem_addr_o(imemAddr),
    .imem_wdata_o(imemWdata),
    .cpu_reset_o(cpuReset),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (imemWe === 1'b1) begin
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("[TB] FAIL unexpected_write: observed addr 0x%02h data 0x%08h expected no write",
               imemAddr, imemWdata);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("write_addr", 32'(imemAddr), 32'(e.addr));
        checkOutput("write_data", imemWdata, e.data);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int guard;
    bit ok;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byteValid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    byteIn    = b;
    byteValid = 1'b1;
    guard     = 0;
    ok        = 1'b0;
    while (!ok && guard < 20) begin
      @(negedge clock);
      if (byteReady === 1'b1) ok = 1'b1;
      else guard++;
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end else begin
      compared++;
      mismatched++;
      $error("[TB] FAIL byte_timeout: observed byte_ready_o low for 20 cycles expected acceptance of 0x%02h", b);
    end
    byteValid = 1'b0;
  endtask

  task automatic startLoad();
    startIn = 1'b1;
    @(posedge clock);
    #1;
    startIn = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic sendGood(input logic [7:0] csumByte, input bit gaps);
    logic [7:0] stream [10];
    stream = '{8'h02, 8'h20, 8'h00, 8'h01, 8'hFD, 8'h28, 8'h00, 8'h02, 8'h00, 8'h00};
    stream[9] = csumByte;
    sb.push_back('{addr: 8'd0, data: 32'h200001FD});
    sb.push_back('{addr: 8'd1, data: 32'h28000200});
    startLoad();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(stream[i], gaps);
      if (gaps && i == 4) begin
        startIn = 1'b1;
        @(posedge clock);
        #1;
        startIn = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    startIn   = 1'b0;
    byteIn    = 8'h00;
    byteValid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("rst_ready",   32'(byteReady), 32'd0);
    checkOutput("rst_we",      32'(imemWe),    32'd0);
    checkOutput("rst_addr",    32'(imemAddr),  32'd0);
    checkOutput("rst_wdata",   imemWdata,      32'd0);
    checkOutput("rst_cpu",     32'(cpuReset),  32'd1);
    checkOutput("rst_busy",    32'(busy),      32'd0);
    checkOutput("rst_done",    32'(done),      32'd0);
    checkOutput("rst_err",     32'(err),       32'd0);

    $display("[TB] good load");
    sendGood(8'hF6, 1'b0);
    checkOutput("good_done",    32'(done),     32'd1);
    checkOutput("good_err",     32'(err),      32'd0);
    checkOutput("good_cpu",     32'(cpuReset), 32'd0);
    checkOutput("good_busy",    32'(busy),     32'd0);
    checkOutput("good_ready",   32'(byteReady), 32'd0);
    checkOutput("good_pending", 32'(sb.size()), 32'd0);

    $display("[TB] bad checksum");
    sendGood(8'hF7, 1'b0);
    checkOutput("bad_err",     32'(err),      32'd1);
    checkOutput("bad_done",    32'(done),     32'd0);
    checkOutput("bad_cpu",     32'(cpuReset), 32'd1);
    checkOutput("bad_pending", 32'(sb.size()), 32'd0);

    $display("[TB] zero length");
    startLoad();
    checkOutput("zero_len_ready", 32'(byteReady), 32'd1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("zero_csum_busy", 32'(busy), 32'd1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("zero_done", 32'(done),     32'd1);
    checkOutput("zero_cpu",  32'(cpuReset), 32'd0);

    $display("[TB] oversize count");
    startLoad();
    applyStimulus(8'h05, 1'b0);
    checkOutput("over_err",   32'(err),       32'd1);
    checkOutput("over_ready", 32'(byteReady), 32'd0);
    checkOutput("over_busy",  32'(busy),      32'd0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("over_pending", 32'(sb.size()), 32'd0);

    $display("[TB] backpressure and gaps");
    pulseReset();
    byteIn    = 8'hAA;
    byteValid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("idle_valid_busy",  32'(busy),      32'd0);
    checkOutput("idle_valid_ready", 32'(byteReady), 32'd0);
    byteValid = 1'b0;
    sendGood(8'hF6, 1'b1);
    checkOutput("gap_done",    32'(done),      32'd1);
    checkOutput("gap_pending", 32'(sb.size()), 32'd0);

    $display("[TB] reset mid-load");
    startLoad();
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    pulseReset();
    checkOutput("midrst_busy",  32'(busy),      32'd0);
    checkOutput("midrst_ready", 32'(byteReady), 32'd0);
    checkOutput("midrst_cpu",   32'(cpuReset),  32'd1);
    checkOutput("midrst_we",    32'(imemWe),    32'd0);
    repeat (5) @(posedge clock);
    #1;
    sendGood(8'hF6, 1'b0);
    checkOutput("after_rst_done",    32'(done),      32'd1);
    checkOutput("after_rst_pending", 32'(sb.size()), 32'd0);

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
